id_stage_pipe: RTL and testbench

//  Parametrised MIPS decode stage with an integrated ID/EX pipeline register.

---
 rtl/id_stage_pipe.sv | 250 +++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - MIPS decode stage with operand forwarding, load-use stall and ID/EX register
// Purpose: decodes logic/shift/arithmetic/compare ops, selects operands (immediate, r0,
//   forwarded result, register file), raises a load-use stall request and registers
//   the decoded instruction into ID/EX with flush/stall/bubble handling.
// Ports:
//   clk, rst (sync, active-high); stall_i, flush_i from ctrl
//   pc_i, inst_i from if_id; rf1/rf2 read port (re/addr out, data in)
//   fwd_we_i/fwd_wd_i/fwd_wdata_i: FWD_N forwarding sources, slot 0 = EX
//   ex_is_load_i: EX holds a load; stall_req_o: load-use stall request
//   ex_*: registered pc, aluop, alusel, operands, destination, write enable, illegal flag
module id_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FWD_N   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                inst_i,
  input  logic [DATA_W-1:0]          rf1_data_i,
  input  logic [DATA_W-1:0]          rf2_data_i,
  output logic                       rf1_re_o,
  output logic [RADDR_W-1:0]         rf1_addr_o,
  output logic                       rf2_re_o,
  output logic [RADDR_W-1:0]         rf2_addr_o,
  input  logic [FWD_N-1:0]           fwd_we_i,
  input  logic [FWD_N*RADDR_W-1:0]   fwd_wd_i,
  input  logic [FWD_N*DATA_W-1:0]    fwd_wdata_i,
  input  logic                       ex_is_load_i,
  output logic                       stall_req_o,
  output logic [31:0]                ex_pc_o,
  output logic [7:0]                 ex_aluop_o,
  output logic [2:0]                 ex_alusel_o,
  output logic [DATA_W-1:0]          ex_reg1_o,
  output logic [DATA_W-1:0]          ex_reg2_o,
  output logic [RADDR_W-1:0]         ex_wd_o,
  output logic                       ex_wreg_o,
  output logic                       ex_illegal_o
);

  localparam logic [7:0] EXE_NOP_OP   = 8'h00, EXE_SRL_OP   = 8'h02, EXE_SRA_OP   = 8'h03;
  localparam logic [7:0] EXE_SLLV_OP  = 8'h04, EXE_SRLV_OP  = 8'h06, EXE_SRAV_OP  = 8'h07;
  localparam logic [7:0] EXE_ADD_OP   = 8'h20, EXE_ADDU_OP  = 8'h21, EXE_SUB_OP   = 8'h22;
  localparam logic [7:0] EXE_SUBU_OP  = 8'h23, EXE_AND_OP   = 8'h24, EXE_OR_OP    = 8'h25;
  localparam logic [7:0] EXE_XOR_OP   = 8'h26, EXE_NOR_OP   = 8'h27, EXE_SLT_OP   = 8'h2A;
  localparam logic [7:0] EXE_SLTU_OP  = 8'h2B, EXE_ADDI_OP  = 8'h55, EXE_ADDIU_OP = 8'h56;
  localparam logic [7:0] EXE_SLTI_OP  = 8'h57, EXE_SLTIU_OP = 8'h58, EXE_ANDI_OP  = 8'h59;
  localparam logic [7:0] EXE_ORI_OP   = 8'h5A, EXE_XORI_OP  = 8'h5B, EXE_LUI_OP   = 8'h5C;
  localparam logic [7:0] EXE_SLL_OP   = 8'h7C;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  logic [5:0]         opcode, funct;
  logic [15:0]        imm16;
  logic [RADDR_W-1:0] raddr1, raddr2, rd_addr, ex_dst;
  logic [DATA_W-1:0]  imm_zext, imm_sext, imm_lui, imm_shamt;

  assign opcode    = inst_i[31:26];
  assign funct     = inst_i[5:0];
  assign imm16     = inst_i[15:0];
  assign raddr1    = RADDR_W'(inst_i[25:21]);
  assign raddr2    = RADDR_W'(inst_i[20:16]);
  assign rd_addr   = RADDR_W'(inst_i[15:11]);
  assign imm_zext  = DATA_W'(imm16);
  assign imm_sext  = {{(DATA_W-16){imm16[15]}}, imm16};
  assign imm_lui   = {imm16, {(DATA_W-16){1'b0}}};
  assign imm_shamt = DATA_W'(inst_i[10:6]);

  logic [7:0]         dec_aluop;
  logic [2:0]         dec_alusel;
  logic               dec_wreg, dec_illegal, dec_re1, dec_re2, dec_itype;
  logic [RADDR_W-1:0] dec_wd;
  logic [DATA_W-1:0]  dec_imm;

  always_comb begin
    dec_aluop   = EXE_NOP_OP;
    dec_alusel  = EXE_RES_NOP;
    dec_wreg    = 1'b0;
    dec_wd      = '0;
    dec_re1     = 1'b0;
    dec_re2     = 1'b0;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    dec_itype   = 1'b1;
    case (opcode)
      6'h00: begin
        dec_itype = 1'b0;
        dec_wreg  = 1'b1;
        dec_wd    = rd_addr;
        dec_re1   = 1'b1;
        dec_re2   = 1'b1;
        case (funct)
          6'h25: begin dec_aluop = EXE_OR_OP;   dec_alusel = EXE_RES_LOGIC; end
          6'h24: begin dec_aluop = EXE_AND_OP;  dec_alusel = EXE_RES_LOGIC; end
          6'h26: begin dec_aluop = EXE_XOR_OP;  dec_alusel = EXE_RES_LOGIC; end
          6'h27: begin dec_aluop = EXE_NOR_OP;  dec_alusel = EXE_RES_LOGIC; end
          6'h04: begin dec_aluop = EXE_SLLV_OP; dec_alusel = EXE_RES_SHIFT; end
          6'h06: begin dec_aluop = EXE_SRLV_OP; dec_alusel = EXE_RES_SHIFT; end
          6'h07: begin dec_aluop = EXE_SRAV_OP; dec_alusel = EXE_RES_SHIFT; end
          6'h20: begin dec_aluop = EXE_ADD_OP;  dec_alusel = EXE_RES_ARITH; end
          6'h21: begin dec_aluop = EXE_ADDU_OP; dec_alusel = EXE_RES_ARITH; end
          6'h22: begin dec_aluop = EXE_SUB_OP;  dec_alusel = EXE_RES_ARITH; end
          6'h23: begin dec_aluop = EXE_SUBU_OP; dec_alusel = EXE_RES_ARITH; end
          6'h2A: begin dec_aluop = EXE_SLT_OP;  dec_alusel = EXE_RES_ARITH; end
          6'h2B: begin dec_aluop = EXE_SLTU_OP; dec_alusel = EXE_RES_ARITH; end
          // Immediate shifts: shamt rides in operand 1, rs is not read.
          6'h00: begin dec_aluop = EXE_SLL_OP; dec_alusel = EXE_RES_SHIFT; dec_re1 = 1'b0; dec_imm = imm_shamt; end
          6'h02: begin dec_aluop = EXE_SRL_OP; dec_alusel = EXE_RES_SHIFT; dec_re1 = 1'b0; dec_imm = imm_shamt; end
          6'h03: begin dec_aluop = EXE_SRA_OP; dec_alusel = EXE_RES_SHIFT; dec_re1 = 1'b0; dec_imm = imm_shamt; end
          6'h0F: begin dec_wreg = 1'b0; dec_wd = '0; dec_re1 = 1'b0; dec_re2 = 1'b0; end
          default: begin
            dec_illegal = 1'b1;
            dec_wreg    = 1'b0;
            dec_wd      = '0;
            dec_re1     = 1'b0;
            dec_re2     = 1'b0;
          end
        endcase
      end
      6'h0D: begin dec_aluop = EXE_ORI_OP;   dec_alusel = EXE_RES_LOGIC; dec_imm = imm_zext; end
      6'h0C: begin dec_aluop = EXE_ANDI_OP;  dec_alusel = EXE_RES_LOGIC; dec_imm = imm_zext; end
      6'h0E: begin dec_aluop = EXE_XORI_OP;  dec_alusel = EXE_RES_LOGIC; dec_imm = imm_zext; end
      6'h0F: begin dec_aluop = EXE_LUI_OP;   dec_alusel = EXE_RES_LOGIC; dec_imm = imm_lui;  end
      6'h08: begin dec_aluop = EXE_ADDI_OP;  dec_alusel = EXE_RES_ARITH; dec_imm = imm_sext; end
      6'h09: begin dec_aluop = EXE_ADDIU_OP; dec_alusel = EXE_RES_ARITH; dec_imm = imm_sext; end
      6'h0A: begin dec_aluop = EXE_SLTI_OP;  dec_alusel = EXE_RES_ARITH; dec_imm = imm_sext; end
      6'h0B: begin dec_aluop = EXE_SLTIU_OP; dec_alusel = EXE_RES_ARITH; dec_imm = imm_sext; end
      6'h33: dec_itype = 1'b0;  // PREF: architectural no-op
      default: begin dec_itype = 1'b0; dec_illegal = 1'b1; end
    endcase
    if (dec_itype) begin
      dec_wreg = 1'b1;
      dec_wd   = raddr2;
      // LUI carries its whole value in the immediate, so rs is left unread.
      dec_re1  = (opcode != 6'h0F);
    end
  end

  // Lowest-numbered (youngest) matching source wins, so scan from the oldest down.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic                     re,
    input logic [RADDR_W-1:0]       addr,
    input logic [DATA_W-1:0]        imm,
    input logic [DATA_W-1:0]        rf_data,
    input logic [FWD_N-1:0]         we,
    input logic [FWD_N*RADDR_W-1:0] wd,
    input logic [FWD_N*DATA_W-1:0]  wdata
  );
    logic [DATA_W-1:0] v;
    if (!re) v = imm;
    else if (addr == '0) v = '0;
    else begin
      v = rf_data;
      for (int k = FWD_N - 1; k >= 0; k--)
        if (we[k] && wd[k*RADDR_W +: RADDR_W] == addr) v = wdata[k*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  logic [DATA_W-1:0] opnd1, opnd2;
  logic              hazard;

  assign opnd1 = pick_operand(dec_re1, raddr1, dec_imm, rf1_data_i, fwd_we_i, fwd_wd_i, fwd_wdata_i);
  assign opnd2 = pick_operand(dec_re2, raddr2, dec_imm, rf2_data_i, fwd_we_i, fwd_wd_i, fwd_wdata_i);

  assign ex_dst = fwd_wd_i[RADDR_W-1:0];
  assign hazard = ex_is_load_i && fwd_we_i[0] && (ex_dst != '0) &&
                  ((dec_re1 && ex_dst == raddr1) || (dec_re2 && ex_dst == raddr2));

  assign stall_req_o = hazard && !rst;
  assign rf1_re_o    = dec_re1 && !rst;
  assign rf2_re_o    = dec_re2 && !rst;
  assign rf1_addr_o  = rst ? '0 : raddr1;
  assign rf2_addr_o  = rst ? '0 : raddr2;

  logic [31:0]        pc_d, pc_q;
  logic [7:0]         aluop_d, aluop_q;
  logic [2:0]         alusel_d, alusel_q;
  logic [DATA_W-1:0]  reg1_d, reg1_q, reg2_d, reg2_q;
  logic [RADDR_W-1:0] wd_d, wd_q;
  logic               wreg_d, wreg_q, illegal_d, illegal_q;

  always_comb begin
    pc_d      = pc_q;
    aluop_d   = aluop_q;
    alusel_d  = alusel_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    illegal_d = illegal_q;
    // Flush beats hold; an unheld hazard turns into a bubble (same all-zero NOP).
    if (flush_i || (!stall_i && hazard)) begin
      pc_d      = '0;
      aluop_d   = EXE_NOP_OP;
      alusel_d  = EXE_RES_NOP;
      reg1_d    = '0;
      reg2_d    = '0;
      wd_d      = '0;
      wreg_d    = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall_i) begin
      pc_d      = pc_i;
      aluop_d   = dec_aluop;
      alusel_d  = dec_alusel;
      reg1_d    = opnd1;
      reg2_d    = opnd2;
      wd_d      = dec_wd;
      wreg_d    = dec_wreg;
      illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      aluop_q   <= EXE_NOP_OP;
      alusel_q  <= EXE_RES_NOP;
      reg1_q    <= '0;
      reg2_q    <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      aluop_q   <= aluop_d;
      alusel_q  <= alusel_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_pc_o      = pc_q;
  assign ex_aluop_o   = aluop_q;
  assign ex_alusel_o  = alusel_q;
  assign ex_reg1_o    = reg1_q;
  assign ex_reg2_o    = reg2_q;
  assign ex_wd_o      = wd_q;
  assign ex_wreg_o    = wreg_q;
  assign ex_illegal_o = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - self-checking bench for id_stage_pipe
module tb_id_stage_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FN = 2;

  logic            clk = 1'b0;
  logic            rst, stall_i, flush_i, ex_is_load_i;
  logic [31:0]     pc_i, inst_i;
  logic [DW-1:0]   rf1_data_i, rf2_data_i;
  logic            rf1_re_o, rf2_re_o, stall_req_o;
  logic [AW-1:0]   rf1_addr_o, rf2_addr_o;
  logic [FN-1:0]   fwd_we_i;
  logic [FN*AW-1:0] fwd_wd_i;
  logic [FN*DW-1:0] fwd_wdata_i;
  logic [31:0]     ex_pc_o;
  logic [7:0]      ex_aluop_o;
  logic [2:0]      ex_alusel_o;
  logic [DW-1:0]   ex_reg1_o, ex_reg2_o;
  logic [AW-1:0]   ex_wd_o;
  logic            ex_wreg_o, ex_illegal_o;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(DW), .RADDR_W(AW), .FWD_N(FN)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .inst_i(inst_i), .rf1_data_i(rf1_data_i), .rf2_data_i(rf2_data_i),
    .rf1_re_o(rf1_re_o), .rf1_addr_o(rf1_addr_o), .rf2_re_o(rf2_re_o), .rf2_addr_o(rf2_addr_o),
    .fwd_we_i(fwd_we_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_is_load_i(ex_is_load_i), .stall_req_o(stall_req_o),
    .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o),
    .ex_wreg_o(ex_wreg_o), .ex_illegal_o(ex_illegal_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        wreg;
    logic [4:0]  wd;
    logic        use_rs;
    logic        use_rt;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  // Expected ID/EX contents.
  logic [31:0] e_pc, e_reg1, e_reg2;
  logic [7:0]  e_aluop;
  logic [2:0]  e_alusel;
  logic [4:0]  e_wd;
  logic        e_wreg, e_illegal;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics: R-type aluop mirrors funct, except SLL which would alias NOP.
  function automatic dec_t ref_decode(input logic [31:0] in);
    dec_t d;
    logic [5:0] op, fn;
    op = in[31:26];
    fn = in[5:0];
    d  = '0;
    if (op == 6'h00) begin
      if (fn == 6'h0F) return d;
      if (fn inside {6'h24, 6'h25, 6'h26, 6'h27}) d.alusel = 3'd1;
      else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) d.alusel = 3'd2;
      else if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B}) d.alusel = 3'd4;
      else begin d.illegal = 1'b1; return d; end
      d.aluop  = (fn == 6'h00) ? 8'h7C : {2'b00, fn};
      d.wreg   = 1'b1;
      d.wd     = in[15:11];
      d.use_rt = 1'b1;
      d.use_rs = !(fn inside {6'h00, 6'h02, 6'h03});
      if (!d.use_rs) d.imm = {27'd0, in[10:6]};
    end else begin
      case (op)
        6'h0D: begin d.aluop = 8'h5A; d.alusel = 3'd1; d.imm = {16'd0, in[15:0]}; end
        6'h0C: begin d.aluop = 8'h59; d.alusel = 3'd1; d.imm = {16'd0, in[15:0]}; end
        6'h0E: begin d.aluop = 8'h5B; d.alusel = 3'd1; d.imm = {16'd0, in[15:0]}; end
        6'h0F: begin d.aluop = 8'h5C; d.alusel = 3'd1; d.imm = {in[15:0], 16'd0}; end
        6'h08: begin d.aluop = 8'h55; d.alusel = 3'd4; d.imm = 32'($signed(in[15:0])); end
        6'h09: begin d.aluop = 8'h56; d.alusel = 3'd4; d.imm = 32'($signed(in[15:0])); end
        6'h0A: begin d.aluop = 8'h57; d.alusel = 3'd4; d.imm = 32'($signed(in[15:0])); end
        6'h0B: begin d.aluop = 8'h58; d.alusel = 3'd4; d.imm = 32'($signed(in[15:0])); end
        6'h33: return d;
        default: begin d.illegal = 1'b1; return d; end
      endcase
      d.wreg   = 1'b1;
      d.wd     = in[20:16];
      d.use_rs = (op != 6'h0F);
    end
    return d;
  endfunction

  function automatic logic [31:0] ref_operand(input logic use_r, input logic [4:0] a,
                                              input logic [31:0] imm, input logic [31:0] rf);
    if (!use_r) return imm;
    if (a == 5'd0) return 32'd0;
    for (int k = 0; k < FN; k++)
      if (fwd_we_i[k] && fwd_wd_i[k*AW +: AW] == a) return fwd_wdata_i[k*DW +: DW];
    return rf;
  endfunction

  // One clock: check combinational outputs, advance the model, check ID/EX.
  task automatic step(input string tag);
    dec_t d;
    logic haz;
    logic [31:0] o1, o2;
    #1;
    d   = ref_decode(inst_i);
    haz = !rst && ex_is_load_i && fwd_we_i[0] && (fwd_wd_i[4:0] != 5'd0) &&
          ((d.use_rs && fwd_wd_i[4:0] == inst_i[25:21]) || (d.use_rt && fwd_wd_i[4:0] == inst_i[20:16]));
    o1  = ref_operand(d.use_rs, inst_i[25:21], d.imm, rf1_data_i);
    o2  = ref_operand(d.use_rt, inst_i[20:16], d.imm, rf2_data_i);
    chk({tag, ":stall_req"}, stall_req_o, haz);
    chk({tag, ":rf1_re"}, rf1_re_o, rst ? 1'b0 : d.use_rs);
    chk({tag, ":rf2_re"}, rf2_re_o, rst ? 1'b0 : d.use_rt);
    chk({tag, ":rf1_addr"}, rf1_addr_o, rst ? 5'd0 : inst_i[25:21]);
    chk({tag, ":rf2_addr"}, rf2_addr_o, rst ? 5'd0 : inst_i[20:16]);
    @(posedge clk);
    if (rst || flush_i || (!stall_i && haz)) begin
      e_pc = 0; e_aluop = 0; e_alusel = 0; e_reg1 = 0; e_reg2 = 0; e_wd = 0; e_wreg = 0; e_illegal = 0;
    end else if (!stall_i) begin
      e_pc = pc_i; e_aluop = d.aluop; e_alusel = d.alusel; e_reg1 = o1; e_reg2 = o2;
      e_wd = d.wd; e_wreg = d.wreg; e_illegal = d.illegal;
    end
    #1;
    chk({tag, ":pc"}, ex_pc_o, e_pc);
    chk({tag, ":aluop"}, ex_aluop_o, e_aluop);
    chk({tag, ":alusel"}, ex_alusel_o, e_alusel);
    chk({tag, ":reg1"}, ex_reg1_o, e_reg1);
    chk({tag, ":reg2"}, ex_reg2_o, e_reg2);
    chk({tag, ":wd"}, ex_wd_o, e_wd);
    chk({tag, ":wreg"}, ex_wreg_o, e_wreg);
    chk({tag, ":illegal"}, ex_illegal_o, e_illegal);
  endtask

  task automatic set_fwd(input logic we0, input logic [4:0] wd0, input logic [31:0] d0,
                         input logic we1, input logic [4:0] wd1, input logic [31:0] d1);
    fwd_we_i    = {we1, we0};
    fwd_wd_i    = {wd1, wd0};
    fwd_wdata_i = {d1, d0};
  endtask

  logic [11:0] pool [0:27];

  initial begin
    logic [31:0] r;
    logic [11:0] p;
    pool = '{12'h000, 12'h002, 12'h003, 12'h004, 12'h006, 12'h007, 12'h00F, 12'h020,
             12'h021, 12'h022, 12'h023, 12'h024, 12'h025, 12'h026, 12'h027, 12'h02A,
             12'h02B, 12'h340, 12'h300, 12'h380, 12'h3C0, 12'h200, 12'h240, 12'h280,
             12'h2C0, 12'hCC0, 12'hFC0, 12'h001};
    e_pc = 0; e_aluop = 0; e_alusel = 0; e_reg1 = 0; e_reg2 = 0; e_wd = 0; e_wreg = 0; e_illegal = 0;
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; ex_is_load_i = 1'b0;
    pc_i = 32'h100; rf1_data_i = 32'h1111; rf2_data_i = 32'h2222;
    // Reset with a would-be hazard on the inputs: combinational outputs stay 0.
    inst_i = 32'h00A53020;
    set_fwd(1'b1, 5'd5, 32'h9, 1'b0, 5'd0, 32'h0);
    ex_is_load_i = 1'b1;
    @(posedge clk);
    step("reset");
    rst = 1'b0; ex_is_load_i = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // ori r1,r0,0x1234
    inst_i = 32'h34011234; pc_i = 32'h104;
    step("ori");
    chk("ori:reg1_const", ex_reg1_o, 32'h0);
    chk("ori:reg2_const", ex_reg2_o, 32'h00001234);
    chk("ori:wd_const", ex_wd_o, 5'd1);
    chk("ori:aluop_const", ex_aluop_o, 8'h5A);

    // addi r2,r1,0xFFFF then andi r2,r1,0xFFFF
    inst_i = 32'h2022FFFF; pc_i = 32'h108;
    step("addi");
    chk("addi:reg2_const", ex_reg2_o, 32'hFFFFFFFF);
    inst_i = 32'h3022FFFF; pc_i = 32'h10C;
    step("andi");
    chk("andi:reg2_const", ex_reg2_o, 32'h0000FFFF);

    // or r4,r3,r0 with both sources targeting r3
    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    inst_i = 32'h00602025; pc_i = 32'h110;
    step("fwdprio");
    chk("fwdprio:reg1_const", ex_reg1_o, 32'hAA);
    chk("fwdprio:reg2_const", ex_reg2_o, 32'h0);

    // add r6,r5,r5 behind a load to r5: one bubble, then issue with the MEM forward
    set_fwd(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    ex_is_load_i = 1'b1;
    inst_i = 32'h00A53020; pc_i = 32'h114;
    step("loaduse");
    chk("loaduse:stall_const", stall_req_o, 1'b1);
    chk("loaduse:bubble_wreg", ex_wreg_o, 1'b0);
    ex_is_load_i = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h7);
    step("loaduse2");
    chk("loaduse2:reg1_const", ex_reg1_o, 32'h7);
    chk("loaduse2:reg2_const", ex_reg2_o, 32'h7);
    chk("loaduse2:aluop_const", ex_aluop_o, 8'h20);

    // flush with stall_i, flush with stall_req
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    flush_i = 1'b1; stall_i = 1'b1; inst_i = 32'h34011234;
    step("flush_stall");
    stall_i = 1'b0; ex_is_load_i = 1'b1; inst_i = 32'h00A53020;
    set_fwd(1'b1, 5'd5, 32'h3, 1'b0, 5'd0, 32'h0);
    step("flush_haz");
    chk("flush_haz:aluop_const", ex_aluop_o, 8'h00);
    flush_i = 1'b0; ex_is_load_i = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // hold for three cycles while the input instruction changes
    inst_i = 32'h34011234; pc_i = 32'h200;
    step("preload");
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_i = 32'h2022FFFF; pc_i = 32'h300 + 32'(i);
      step("hold");
      chk("hold:reg2_const", ex_reg2_o, 32'h1234);
      chk("hold:pc_const", ex_pc_o, 32'h200);
    end
    // reset during stall with a live hazard
    rst = 1'b1; ex_is_load_i = 1'b1; inst_i = 32'h00A53020;
    set_fwd(1'b1, 5'd5, 32'h3, 1'b0, 5'd0, 32'h0);
    step("rst_stall");
    chk("rst_stall:reg2_const", ex_reg2_o, 32'h0);
    rst = 1'b0; stall_i = 1'b0; ex_is_load_i = 1'b0;

    // sll r7,r8,5
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    inst_i = 32'h00083940; rf2_data_i = 32'h0F0;
    #1;
    chk("sll:rf1_re_const", rf1_re_o, 1'b0);
    step("sll");
    chk("sll:reg1_const", ex_reg1_o, 32'h5);
    // or r9,r0,r0 with a source claiming r0
    set_fwd(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    inst_i = 32'h00004825;
    step("r0fwd");
    chk("r0fwd:reg1_const", ex_reg1_o, 32'h0);
    // sync, pref, illegal
    inst_i = 32'h0000000F; step("sync");
    inst_i = 32'hCC000000; step("pref");
    inst_i = 32'hFC000000; step("illegal");
    chk("illegal:flag_const", ex_illegal_o, 1'b1);
    chk("illegal:aluop_const", ex_aluop_o, 8'h00);

    // randomized traffic with small register numbers to provoke matches
    for (int n = 0; n < 400; n++) begin
      p = pool[$urandom_range(0, 27)];
      r = $urandom;
      r[24:23] = 2'b00;
      r[19:18] = 2'b00;
      inst_i = {p[11:6], r[25:6], (p[11:6] == 6'h00) ? p[5:0] : r[5:0]};
      pc_i = $urandom;
      rf1_data_i = $urandom;
      rf2_data_i = $urandom;
      set_fwd($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      ex_is_load_i = ($urandom_range(0, 2) == 0);
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
